// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register array and its write/read controller.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam int unsigned CTRL_MAX_REQ = 8;

    // Circular increment; depth need not be a power of two.
    function automatic address_t next_ptr(input address_t ptr, input int unsigned depth);
        if ({27'd0, ptr} == depth - 1)
            return '0;
        return ptr + address_t'(1);
    endfunction

endpackage

// File: rtl/instr_register_ctrl_if.sv
// Producer, register-write and consumer signals of the instruction register controller.
interface instr_register_ctrl_if
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 32
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                clear;
    logic [NUM_REQ-1:0]  req_valid;
    opcode_t             req_opcode    [NUM_REQ];
    operand_t            req_operand_a [NUM_REQ];
    operand_t            req_operand_b [NUM_REQ];
    logic [NUM_REQ-1:0]  req_ready;

    logic                load_en;
    opcode_t             opcode;
    operand_t            operand_a;
    operand_t            operand_b;
    address_t            write_pointer;

    address_t            read_pointer;
    logic                rd_pop;
    logic                rd_valid;
    logic [CW-1:0]       count;

    modport master (
        input  clear, req_valid, req_opcode, req_operand_a, req_operand_b, rd_pop,
        output req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
               read_pointer, rd_valid, count
    );

    modport slave (
        output clear, req_valid, req_opcode, req_operand_a, req_operand_b, rd_pop,
        input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
               read_pointer, rd_valid, count
    );

endinterface

// File: rtl/instr_register_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after last_grant.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant
);

    always_comb begin
        logic          found;
        logic [GW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Offsets 1..N visit every requester once, ending on last_grant itself.
        for (int unsigned off = 1; off <= N; off++) begin
            idx = GW'(({{(32-GW){1'b0}}, last_grant} + off) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// Arbitrates producers onto the instruction register write port and tracks the
// array as a circular buffer for the consumer.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_register_ctrl_if.master bus
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (NUM_REQ < 1 || NUM_REQ > CTRL_MAX_REQ) begin : g_bad_num_req
        $error("instr_register_ctrl: NUM_REQ out of range");
    end
    if (DEPTH < 2 || DEPTH > 2 ** $bits(address_t)) begin : g_bad_depth
        $error("instr_register_ctrl: DEPTH out of range");
    end

    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [CW:0]        space;
    logic               grant_en;
    logic               accept;
    logic               pop;

    logic               load_q;
    instruction_t       wr_data_q;
    address_t           wp_q;
    address_t           wr_ptr;
    address_t           rd_ptr;
    logic [CW-1:0]      count_q;

    // A pending load already owns a slot, so it counts against free space.
    always_comb begin
        space    = (CW+1)'(DEPTH) - {1'b0, count_q} - (CW+1)'(load_q);
        grant_en = (space != '0) && !bus.clear && !reset;
        accept   = |(bus.req_valid & grant);
        pop      = bus.rd_pop && (count_q != '0);
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .enable     (grant_en),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i])
                grant_idx = GW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q     <= 1'b0;
            wr_data_q  <= '{opc: ZERO, op_a: '0, op_b: '0};
            wp_q       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else if (bus.clear) begin
            load_q  <= 1'b0;
            count_q <= '0;
            rd_ptr  <= wr_ptr;
        end else begin
            if (load_q)
                wr_ptr <= next_ptr(wr_ptr, DEPTH);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr, DEPTH);
            count_q <= count_q + CW'(load_q) - CW'(pop);
            load_q  <= accept;
            if (accept) begin
                last_grant     <= grant_idx;
                wr_data_q.opc  <= bus.req_opcode[grant_idx];
                wr_data_q.op_a <= bus.req_operand_a[grant_idx];
                wr_data_q.op_b <= bus.req_operand_b[grant_idx];
                // Back-to-back accept: the slot after the one committing this edge.
                wp_q           <= load_q ? next_ptr(wr_ptr, DEPTH) : wr_ptr;
            end
        end
    end

    assign bus.req_ready     = grant;
    assign bus.load_en       = load_q;
    assign bus.opcode        = wr_data_q.opc;
    assign bus.operand_a     = wr_data_q.op_a;
    assign bus.operand_b     = wr_data_q.op_b;
    assign bus.write_pointer = wp_q;
    assign bus.read_pointer  = rd_ptr;
    assign bus.rd_valid      = (count_q != '0);
    assign bus.count         = count_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_count_bound:  assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl with NUM_REQ=2, DEPTH=32.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    instr_register_ctrl_if #(.NUM_REQ(2), .DEPTH(32)) bus ();

    instr_register_ctrl #(.NUM_REQ(2), .DEPTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset                = 1'b1;
        bus.clear            = 1'b0;
        bus.rd_pop           = 1'b0;
        bus.req_valid        = 2'b01;
        bus.req_opcode[0]    = ZERO;
        bus.req_opcode[1]    = ZERO;
        bus.req_operand_a[0] = 0;
        bus.req_operand_a[1] = 0;
        bus.req_operand_b[0] = 0;
        bus.req_operand_b[1] = 0;
        #12;
        chk("rst_load_en", bus.load_en, 0);
        chk("rst_opcode", bus.opcode, ZERO);
        chk("rst_operand_a", bus.operand_a, 0);
        chk("rst_operand_b", bus.operand_b, 0);
        chk("rst_wp", bus.write_pointer, 0);
        chk("rst_rp", bus.read_pointer, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.req_ready, 2'b00);
        chk("rst_rd_valid", bus.rd_valid, 0);

        // Single request from producer 0
        reset                = 1'b0;
        bus.req_opcode[0]    = ADD;
        bus.req_operand_a[0] = 5;
        bus.req_operand_b[0] = 3;
        #1;
        chk("t1_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        chk("t1_load_en", bus.load_en, 1);
        chk("t1_wp", bus.write_pointer, 0);
        chk("t1_opcode", bus.opcode, ADD);
        chk("t1_operand_a", bus.operand_a, 5);
        chk("t1_operand_b", bus.operand_b, 3);
        chk("t1_not_visible", bus.rd_valid, 0);
        tick();
        chk("t1_load_off", bus.load_en, 0);
        chk("t1_count", bus.count, 1);
        chk("t1_rd_valid", bus.rd_valid, 1);
        chk("t1_rp", bus.read_pointer, 0);

        // Both producers held: alternating grants until full
        bus.req_opcode[0]    = SUB;
        bus.req_opcode[1]    = MULT;
        bus.req_operand_a[0] = 1;
        bus.req_operand_a[1] = 2;
        bus.req_valid        = 2'b11;
        #1;
        for (int k = 0; k <= 33; k++) begin
            chk("fill_ready", bus.req_ready,
                (k <= 30) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
            chk("fill_load_en", bus.load_en, (k >= 1 && k <= 31) ? 1 : 0);
            if (k >= 1 && k <= 31) begin
                chk("fill_wp", bus.write_pointer, k);
                chk("fill_opcode", bus.opcode, ((k - 1) % 2 == 0) ? MULT : SUB);
            end
            chk("fill_count", bus.count, (k == 0) ? 1 : ((k > 32) ? 32 : k));
            tick();
        end

        // Pop from full, single grant lands at wrapped slot 0
        bus.req_opcode[0] = DIV;
        bus.req_opcode[1] = PASSA;
        bus.rd_pop        = 1'b1;
        #1;
        chk("full_ready", bus.req_ready, 2'b00);
        tick();
        bus.rd_pop = 1'b0;
        #1;
        chk("full_pop_count", bus.count, 31);
        chk("full_pop_rp", bus.read_pointer, 1);
        chk("full_pop_ready", bus.req_ready, 2'b01);
        tick();
        chk("wrap_load_en", bus.load_en, 1);
        chk("wrap_wp", bus.write_pointer, 0);
        chk("wrap_opcode", bus.opcode, DIV);
        chk("wrap_ready", bus.req_ready, 2'b00);
        bus.req_valid = 2'b00;
        tick();
        chk("refull_count", bus.count, 32);
        chk("refull_load_en", bus.load_en, 0);

        // Drain to 4, then steady accept+pop across both pointer wraps
        bus.rd_pop = 1'b1;
        repeat (28) tick();
        bus.rd_pop = 1'b0;
        chk("drain_count", bus.count, 4);
        chk("drain_rp", bus.read_pointer, 29);
        bus.req_opcode[0] = PASSB;
        bus.req_valid     = 2'b01;
        #1;
        chk("steady_ready", bus.req_ready, 2'b01);
        tick();
        bus.rd_pop = 1'b1;
        for (int j = 1; j <= 33; j++) begin
            chk("steady_count", bus.count, 4);
            chk("steady_load_en", bus.load_en, 1);
            chk("steady_wp", bus.write_pointer, j % 32);
            chk("steady_rp", bus.read_pointer, (28 + j) % 32);
            tick();
        end
        chk("steady_end_count", bus.count, 4);
        chk("steady_end_wp", bus.write_pointer, 2);
        bus.req_valid = 2'b00;
        bus.rd_pop    = 1'b0;
        tick();
        chk("steady_post_count", bus.count, 5);
        chk("steady_post_load", bus.load_en, 0);
        chk("steady_post_rp", bus.read_pointer, 30);

        // Clear with a pending write at slot 7
        bus.req_valid = 2'b01;
        for (int c = 0; c <= 4; c++) begin
            #1;
            chk("pre_clr_ready", bus.req_ready, 2'b01);
            if (c >= 1)
                chk("pre_clr_wp", bus.write_pointer, 2 + c);
            tick();
        end
        bus.clear = 1'b1;
        #1;
        chk("clr_ready", bus.req_ready, 2'b00);
        chk("clr_pending_load", bus.load_en, 1);
        chk("clr_pending_wp", bus.write_pointer, 7);
        tick();
        bus.clear     = 1'b0;
        bus.req_valid = 2'b00;
        chk("clr_load_en", bus.load_en, 0);
        chk("clr_count", bus.count, 0);
        chk("clr_rd_valid", bus.rd_valid, 0);
        chk("clr_rp", bus.read_pointer, 7);
        bus.rd_pop = 1'b1;
        tick();
        bus.rd_pop = 1'b0;
        chk("empty_pop_count", bus.count, 0);
        chk("empty_pop_rp", bus.read_pointer, 7);
        bus.req_opcode[0]    = ADD;
        bus.req_operand_a[0] = 9;
        bus.req_valid        = 2'b01;
        #1;
        chk("post_clr_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        chk("post_clr_load", bus.load_en, 1);
        chk("post_clr_wp", bus.write_pointer, 7);
        chk("post_clr_operand_a", bus.operand_a, 9);
        tick();
        chk("post_clr_count", bus.count, 1);
        chk("post_clr_rp", bus.read_pointer, 7);
        chk("post_clr_rd_valid", bus.rd_valid, 1);

        // Asynchronous reset mid-burst
        bus.req_opcode[0] = MOD;
        bus.req_opcode[1] = PASSA;
        bus.req_valid     = 2'b11;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_load_en", bus.load_en, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_wp", bus.write_pointer, 0);
        chk("arst_rp", bus.read_pointer, 0);
        chk("arst_ready", bus.req_ready, 2'b00);
        chk("arst_opcode", bus.opcode, ZERO);
        chk("arst_rd_valid", bus.rd_valid, 0);
        tick();
        #2;
        reset             = 1'b0;
        bus.req_opcode[0] = SUB;
        #1;
        chk("arst_rel_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        chk("arst_rel_load", bus.load_en, 1);
        chk("arst_rel_wp", bus.write_pointer, 0);
        chk("arst_rel_opcode", bus.opcode, SUB);
        tick();
        chk("arst_rel_count", bus.count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_register_ctrl.md
Name: instr_register_ctrl

Overview:
Write/read controller for the instruction register array. It round-robin arbitrates NUM_REQ instruction producers onto the single register write port, driving load_en, opcode, operand_a, operand_b and write_pointer. It manages the array as a circular buffer: it tracks occupancy, applies backpressure when full, and advances read_pointer as the consumer pops. It sits between the producers/consumer and the instruction register, replacing direct testbench drive of those signals.

Parameters:
NUM_REQ, 2, number of requesting producers (1..8)
DEPTH, 32, number of instruction register entries (2..2**$bits(address_t)); need not be a power of two

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
clear  input  1  synchronous flush: empties buffer, drops pending write
req_valid  input  NUM_REQ  per-producer request; held until accepted
req_opcode  input  NUM_REQ x opcode_t  per-producer opcode
req_operand_a  input  NUM_REQ x operand_t  per-producer operand A
req_operand_b  input  NUM_REQ x operand_t  per-producer operand B
req_ready  output  NUM_REQ  one-hot grant; transfer when valid & ready
load_en  output  1  write strobe to instruction register (registered)
opcode  output  opcode_t  write data (registered)
operand_a  output  operand_t  write data (registered)
operand_b  output  operand_t  write data (registered)
write_pointer  output  address_t  write address (registered)
read_pointer  output  address_t  address of oldest valid entry
rd_pop  input  1  consumer pop of entry at read_pointer
rd_valid  output  1  buffer non-empty (count != 0)
count  output  $clog2(DEPTH+1)  committed occupancy

Behaviour:
- Reset values: load_en=0, opcode=ZERO, operand_a=0, operand_b=0, write_pointer=0, read_pointer=0, count=0, req_ready=0, rd_valid=0, last_grant=NUM_REQ-1. Reset asserted mid-operation drops any pending write.
- space = DEPTH - count - load_en. A grant is possible only when space != 0, clear=0 and reset=0.
- req_ready is combinational: one-hot on the first valid requester after last_grant in circular order. All zeros if no requester is valid or space==0.
- Accept in cycle N (req_valid[i] & req_ready[i]):
  - Cycle N+1: load_en=1, with opcode/operands from requester i and write_pointer=wr_ptr.
  - last_grant<=i at the end of cycle N.
  - At most one accept per cycle.
- Commit: at the posedge ending a load_en cycle, count increments and wr_ptr advances. load_en deasserts unless a new accept occurred.
- Wrap: wr_ptr and read_pointer go DEPTH-1 -> 0.
- rd_valid = (count != 0). rd_pop with rd_valid=0 is ignored. rd_pop with rd_valid=1 advances read_pointer and decrements count.
- Commit and pop in the same cycle: count unchanged, both pointers advance.
- The write landing in cycle N+1 is not visible to the consumer until N+2. No write/read bypass.
- Full: at space==0 all req_ready=0; producers hold. Back-to-back accepts are allowed while space permits (throughput 1/cycle).
- clear=1 has priority over all events:
  - Next posedge: load_en=0, count=0, read_pointer=wr_ptr (pointers do not reset).
  - req_ready=0 during clear.
  - last_grant unchanged.
- count never exceeds DEPTH; no underflow possible.

Decomposition:
- instr_register_pkg holds opcode_t, operand_t, address_t, instruction_t (existing), plus new constant CTRL_MAX_REQ=8 and function next_ptr(ptr, depth) for wrap arithmetic.
- One sub-module: rr_arbiter (parameter N; inputs req, last_grant, enable; output one-hot grant), purely combinational. The last_grant register lives in the parent.

Test Plan:
- Reset then single req[0] ADD a=5 b=3 -> req_ready=01 same cycle; next cycle load_en=1, write_pointer=0, opcode=ADD, operand_a=5, operand_b=3; count=1 one cycle later, rd_valid=1, read_pointer=0.
- req_valid=11 held continuously, DEPTH=32 -> grants alternate 01,10,01,...; write_pointer 0,1,2,... consecutive; req_ready=00 once count+load_en=32; count saturates at 32.
- Full buffer (count=32), one rd_pop -> count=31, read_pointer=1; next cycle a single grant; the write lands at write_pointer=0 (wrap).
- Steady state: one accept and one pop per cycle with count=4 -> count stays 4; both pointers wrap 31->0 without error.
- Pending write (load_en=1, write_pointer=7) with clear=1 -> next cycle load_en=0, count=0, rd_valid=0, read_pointer=wr_ptr=7.
- Assert reset asynchronously mid-burst between clock edges -> outputs immediately take reset values; after release the first accept writes write_pointer=0.
